keypad_scanner: RTL and testbench

Matrix-keypad front end for the microwave controller: scans a 4x3 active-low key matrix, debounces it, and drives the one-hot `keypad[9:0]` digit bus and the active-low `startn`/`stopn` command lines that the microwave top consumes. It is the transmitting end of the keypad interface whose receiving end is the keypad encoder. It sits between the board pins and `microwave`, in the system clock domain.

---
 rtl/keypad_scanner_pkg.sv | 53 +++++
 rtl/keypad_scanner_debounce.sv | 129 ++++++++++++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 tb/tb_keypad_scanner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared key codes, matrix geometry and debounce states for the keypad scanner
//
// Key index = row*3 + col. Indexes 0..8 are digits 1..9, 9 is '*', 10 is digit 0, 11 is '#'.
// KEY_NONE marks "no single key pressed" (idle or multi-key).

package keypad_scanner_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_ZERO = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        DB_RELEASED        = 2'd0,
        DB_CONFIRM_PRESS   = 2'd1,
        DB_PRESSED         = 2'd2,
        DB_CONFIRM_RELEASE = 2'd3
    } db_state_t;

    // Key index to decimal digit; KEY_NONE for '*', '#' and no key.
    function automatic logic [3:0] key_to_digit(input logic [3:0] code);
        logic [3:0] digit;
        if (code <= 4'd8) begin
            digit = code + 4'd1;
        end else if (code == KEY_ZERO) begin
            digit = 4'd0;
        end else begin
            digit = KEY_NONE;
        end
        return digit;
    endfunction

    // Exactly one pressed key gives its index; none or several give KEY_NONE,
    // so a multi-key chord looks like a release to the debouncer.
    function automatic logic [3:0] snapshot_to_code(input logic [NUM_KEYS-1:0] snap);
        logic [3:0] code;
        logic [3:0] hits;
        code = KEY_NONE;
        hits = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                hits = hits + 4'd1;
                code = 4'(i);
            end
        end
        return (hits == 4'd1) ? code : KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// rtl/keypad_scanner_debounce.sv - per-scan press/release debouncer for the keypad scanner
//
// Ports:
//   clk, resetn   system clock, asynchronous active-low reset
//   scan_done     one-cycle strobe on the column-2 sample (a full scan is complete)
//   scan_code     decoded key code of the completed scan (KEY_NONE if none/multiple)
//   stable_code   debounced key code, KEY_NONE while released
//   key_valid     one-cycle pulse when a new press is accepted (aligned with stable_code change)

module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scan_done,
    input  logic [3:0] scan_code,
    output logic [3:0] stable_code,
    output logic       key_valid
);

    localparam int CW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
    // A single agreeing scan is enough: skip both confirm states.
    localparam bit FAST = (DEBOUNCE_SCANS == 1);

    db_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      cand, cand_nxt;
    logic [3:0]      stable_nxt;
    logic            valid_nxt;
    logic            cnt_done;

    // cnt never exceeds DEBOUNCE_SCANS-1 here, so the sum cannot wrap.
    assign cnt_done = ((cnt + CNT_ONE) == CNT_TARGET);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= DB_RELEASED;
            cnt         <= '0;
            cand        <= KEY_NONE;
            stable_code <= KEY_NONE;
            key_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cand        <= cand_nxt;
            stable_code <= stable_nxt;
            key_valid   <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        stable_nxt = stable_code;
        valid_nxt  = 1'b0;
        if (scan_done) begin
            case (state)
                DB_RELEASED: begin
                    if (scan_code != KEY_NONE) begin
                        if (FAST) begin
                            state_nxt  = DB_PRESSED;
                            stable_nxt = scan_code;
                            valid_nxt  = 1'b1;
                            cnt_nxt    = '0;
                        end else begin
                            state_nxt = DB_CONFIRM_PRESS;
                            cand_nxt  = scan_code;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                DB_CONFIRM_PRESS: begin
                    if (scan_code == cand) begin
                        if (cnt_done) begin
                            state_nxt  = DB_PRESSED;
                            stable_nxt = cand;
                            valid_nxt  = 1'b1;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end else if (scan_code == KEY_NONE) begin
                        state_nxt = DB_RELEASED;
                        cand_nxt  = KEY_NONE;
                        cnt_nxt   = '0;
                    end else begin
                        // A different key restarts confirmation on that key.
                        cand_nxt = scan_code;
                        cnt_nxt  = CNT_ONE;
                    end
                end
                DB_PRESSED: begin
                    if (scan_code != stable_code) begin
                        if (FAST) begin
                            state_nxt  = DB_RELEASED;
                            stable_nxt = KEY_NONE;
                            cnt_nxt    = '0;
                        end else begin
                            state_nxt = DB_CONFIRM_RELEASE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                DB_CONFIRM_RELEASE: begin
                    if (scan_code == stable_code) begin
                        state_nxt = DB_PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt_done) begin
                        state_nxt  = DB_RELEASED;
                        stable_nxt = KEY_NONE;
                        cand_nxt   = KEY_NONE;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = DB_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with debounce and one-hot digit / command outputs
//
// Optional feature macro: KEYPAD_SYNC_EN (2-flop synchronizer on row_n before sampling).
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   row_n[3:0] matrix rows, active-low, pulled up
//   col_n[2:0] column drive, active-low, exactly one bit low
//   keypad[9:0] one-hot debounced digit bus
//   startn     low while '#' held (debounced)
//   stopn      low while '*' held (debounced)
//   key_valid  one-cycle pulse on a newly accepted press

module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       stopn,
    output logic       key_valid
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0]         slot_cnt;
    logic [1:0]            col_idx;
    logic                  slot_last;
    logic                  scan_done;
    logic [3:0]            row_s;
    logic [NUM_KEYS-1:0]   snap_q;
    logic [NUM_KEYS-1:0]   snap_now;
    logic [3:0]            scan_code;
    logic [3:0]            stable_code;
    logic                  db_valid;
    logic [3:0]            digit;
    logic [9:0]            keypad_d;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign row_s = row_sync;
`else
    assign row_s = row_n;
`endif

    // Sampling on the last cycle of a slot gives the column drive (and the
    // optional synchronizer) time to settle before rows are trusted.
    assign slot_last = (slot_cnt == SLOT_LAST);
    assign scan_done = slot_last && (col_idx == 2'd2);

    // Snapshot including the rows being sampled this cycle, so the column-2
    // sample can be decoded and debounced on the same edge it is taken.
    always_comb begin
        snap_now = snap_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_idx == 2'(c)) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    snap_now[r*NUM_COLS + c] = ~row_s[r];
                end
            end
        end
    end

    assign scan_code = snapshot_to_code(snap_now);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col_n    <= 3'b110;
            snap_q   <= '0;
        end else begin
            if (slot_last) begin
                slot_cnt <= '0;
                snap_q   <= snap_now;
                col_n    <= {col_n[1:0], col_n[2]};
                col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .resetn      (resetn),
        .scan_done   (scan_done),
        .scan_code   (scan_code),
        .stable_code (stable_code),
        .key_valid   (db_valid)
    );

    assign digit    = key_to_digit(stable_code);
    assign keypad_d = (digit != KEY_NONE) ? (10'd1 << digit) : 10'd0;

    // key_valid is re-registered alongside the decoded outputs so the pulse
    // lands on the first cycle the new key is visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            keypad    <= 10'd0;
            startn    <= 1'b1;
            stopn     <= 1'b1;
            key_valid <= 1'b0;
        end else begin
            keypad    <= keypad_d;
            startn    <= (stable_code != KEY_HASH);
            stopn     <= (stable_code != KEY_STAR);
            key_valid <= db_valid;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a scan-level reference model

module tb_keypad_scanner;

    localparam int S      = 4;
    localparam int D      = 3;
    localparam int PERIOD = 3 * S;
    localparam int WORST  = (D + 1) * 3 * S + 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       key_valid;
    logic [11:0] mask = 12'h000;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    // Matrix emulation: a held key shorts its row to its column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((mask[r*3 +: 3] & ~col_n) != 3'b000) row_n[r] = 1'b0;
        end
    end

    keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .row_n     (row_n),
        .col_n     (col_n),
        .keypad    (keypad),
        .startn    (startn),
        .stopn     (stopn),
        .key_valid (key_valid)
    );

    // ---------------- reference model ----------------
    int          kcount = 0;
    logic [11:0] m_snap = 12'h000;
    int          hist[$];
    int          m_stable = 15;
    bit          m_pulse = 1'b0;
    logic [9:0]  exp_keypad = 10'd0;
    logic        exp_startn = 1'b1;
    logic        exp_stopn = 1'b1;
    logic        exp_valid = 1'b0;
    logic [2:0]  exp_col = 3'b110;

    function automatic logic [9:0] digit_bus(int code);
        if (code >= 0 && code <= 8) return 10'd1 << (code + 1);
        if (code == 10) return 10'd1;
        return 10'd0;
    endfunction

    function automatic int decode(logic [11:0] s);
        int c = 15;
        if ($countones(s) != 1) return 15;
        for (int i = 0; i < 12; i++) if (s[i]) c = i;
        return c;
    endfunction

    // Debounce as history rule: since the last accepted change, D consecutive
    // identical key scans accept a press; D consecutive scans without the held
    // key accept a release.
    task automatic scan_step(input int code);
        bit all_same = 1'b1;
        bit all_diff = 1'b1;
        hist.push_back(code);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            for (int i = 0; i < D; i++) begin
                if (hist[i] != code) all_same = 1'b0;
                if (hist[i] == m_stable) all_diff = 1'b0;
            end
            if (m_stable == 15 && code != 15 && all_same) begin
                m_stable = code;
                m_pulse  = 1'b1;
                hist.delete();
            end else if (m_stable != 15 && all_diff) begin
                m_stable = 15;
                hist.delete();
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            kcount = 0;
            m_snap = 12'h000;
            hist.delete();
            m_stable = 15;
            m_pulse = 1'b0;
            exp_keypad = 10'd0;
            exp_startn = 1'b1;
            exp_stopn = 1'b1;
            exp_valid = 1'b0;
            exp_col = 3'b110;
        end else begin
            int col;
            exp_keypad = digit_bus(m_stable);
            exp_startn = (m_stable != 11);
            exp_stopn  = (m_stable != 9);
            exp_valid  = m_pulse;
            m_pulse    = 1'b0;
            col = (kcount / S) % 3;
            if (kcount % S == S - 1) begin
                for (int r = 0; r < 4; r++) m_snap[r*3 + col] = mask[r*3 + col];
                if (col == 2) scan_step(decode(m_snap));
            end
            kcount++;
            exp_col = 3'b111 ^ (3'b001 << ((kcount / S) % 3));
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_cnt++;
        if (mon_en) begin
            check("model col_n", col_n, exp_col);
            check("model keypad", keypad, exp_keypad);
            check("model startn", startn, exp_startn);
            check("model stopn", stopn, exp_stopn);
            check("model key_valid", key_valid, exp_valid);
            check("startn/stopn not both low", startn | stopn, 1'b1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_outputs(input logic [11:0] want, input string name);
        int cyc = 0;
        while ({keypad, startn, stopn} !== want && cyc < 2 * WORST) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " reached"}, {keypad, startn, stopn}, want);
        check({name, " latency"}, (cyc <= WORST), 1'b1);
    endtask

    typedef struct {
        logic [11:0] mask;
        logic [9:0]  kp;
        logic        sn;
        logic        pn;
        int          valids;
        string       name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{12'h010, 10'b0000100000, 1'b1, 1'b1, 1, "digit5"};
        vecs[1] = '{12'h800, 10'b0000000000, 1'b0, 1'b1, 1, "hash"};
        vecs[2] = '{12'h200, 10'b0000000000, 1'b1, 1'b0, 1, "star"};
        vecs[3] = '{12'h400, 10'b0000000001, 1'b1, 1'b1, 1, "digit0"};
        vecs[4] = '{12'h001, 10'b0000000010, 1'b1, 1'b1, 1, "digit1"};
        vecs[5] = '{12'h100, 10'b1000000000, 1'b1, 1'b1, 1, "digit9"};
        vecs[6] = '{12'h440, 10'b0000000000, 1'b1, 1'b1, 0, "chord0_7"};
        vecs[7] = '{12'h0C0, 10'b0000000000, 1'b1, 1'b1, 0, "chord7_8"};

        // Reset values
        cycles(3);
        check("reset col_n", col_n, 3'b110);
        check("reset keypad", keypad, 10'd0);
        check("reset startn", startn, 1'b1);
        check("reset stopn", stopn, 1'b1);
        check("reset key_valid", key_valid, 1'b0);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Idle
        valid_cnt = 0;
        cycles(200);
        check("idle key_valid count", valid_cnt, 0);
        check("idle keypad", keypad, 10'd0);

        // Table-driven single keys and chords
        for (int i = 0; i < 8; i++) begin
            valid_cnt = 0;
            mask = vecs[i].mask;
            if (vecs[i].valids != 0) wait_outputs({vecs[i].kp, vecs[i].sn, vecs[i].pn}, vecs[i].name);
            cycles(60);
            check({vecs[i].name, " held outputs"}, {keypad, startn, stopn}, {vecs[i].kp, vecs[i].sn, vecs[i].pn});
            check({vecs[i].name, " key_valid count"}, valid_cnt, vecs[i].valids);
            mask = 12'h000;
            wait_outputs({10'd0, 1'b1, 1'b1}, {vecs[i].name, " release"});
            cycles(60);
        end

        // Bounce on digit 3, phased so no three consecutive col-2 samples agree
        begin
            int guard = 0;
            while (kcount % PERIOD != 0 && guard < 2 * PERIOD) begin
                @(negedge clk);
                guard++;
            end
        end
        valid_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            mask = (t % 2 == 0) ? 12'h004 : 12'h000;
            cycles(5);
        end
        check("bounce keypad", keypad, 10'd0);
        check("bounce key_valid count", valid_cnt, 0);
        mask = 12'h004;
        wait_outputs({10'b0000001000, 1'b1, 1'b1}, "bounce then hold digit3");
        cycles(30);
        check("bounce then hold key_valid count", valid_cnt, 1);
        mask = 12'h000;
        wait_outputs({10'd0, 1'b1, 1'b1}, "digit3 release");
        cycles(30);

        // Chord 0+7, then release 7
        valid_cnt = 0;
        mask = 12'h440;
        cycles(60);
        check("chord keypad", keypad, 10'd0);
        check("chord key_valid count", valid_cnt, 0);
        mask = 12'h400;
        wait_outputs({10'd1, 1'b1, 1'b1}, "chord release 7");
        cycles(5);
        check("chord release 7 key_valid count", valid_cnt, 1);
        mask = 12'h000;
        wait_outputs({10'd0, 1'b1, 1'b1}, "digit0 release");
        cycles(30);

        // Asynchronous reset while digit 9 is reported
        mask = 12'h100;
        wait_outputs({10'b1000000000, 1'b1, 1'b1}, "digit9 before reset");
        cycles(7);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset keypad", keypad, 10'd0);
        check("async reset col_n", col_n, 3'b110);
        check("async reset key_valid", key_valid, 1'b0);
        cycles(4);
        resetn = 1'b1;
        valid_cnt = 0;
        wait_outputs({10'b1000000000, 1'b1, 1'b1}, "digit9 after reset");
        cycles(5);
        check("digit9 after reset key_valid count", valid_cnt, 1);
        mask = 12'h000;
        cycles(60);

        // Randomized patterns against the model
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6) mask = 12'h001 << $urandom_range(0, 11);
            else if (sel < 8) mask = 12'h000;
            else mask = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
            cycles($urandom_range(1, 50));
        end
        mask = 12'h000;
        cycles(60);
        check("final keypad idle", keypad, 10'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
